// File: rtl/mem_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_if
//   Data-memory request/acknowledge bus between the MEM-stage controller and
//   the data memory.
//
//   mem_req    request valid (held until mem_ack)
//   mem_we     1 = write, 0 = read
//   mem_addr   byte/word address
//   mem_wdata  store data
//   mem_ack    memory done; mem_rdata valid in the same cycle on a read
//   mem_rdata  read data
//
//   master : the controller (drives the request)
//   slave  : the memory (drives ack and read data)
// -----------------------------------------------------------------------------
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//   MEM-stage controller fed by the EX/MEM pipeline register.
//   - Resolves branches, jumps, calls and returns (hardware return-address
//     stack) and produces the PC redirect plus the front-end flush.
//   - Runs the data-memory request/ack handshake and stalls the pipeline
//     while memory is busy.
//   - Latches the halt condition (run=0).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   Branch, BranchType    branch/jump flag and condition select
//   call, ret             call / return markers
//   Address, pc_addr      target low bits, PC of the instruction in MEM
//   retAddr               return address pushed on call
//   V, Z, N               ALU flags
//   run                   0 = halt instruction
//   MemRead, MemWrite     memory access request
//   ALU_result, data_r2   memory address, store data
//   mem                   data-memory bus (master side)
//   rdata_q               captured read data for MEM/WB
//   stall                 hold upstream stages, bubble MEM/WB
//   pc_redirect/pc_target PC load request and address
//   flush                 clear IF/ID, ID/EX, EX/MEM
//   halted, ras_err       sticky halt, sticky RAS underflow/overflow
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int RAS_DEPTH = 8,
    parameter int RAS_PTR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Branch,
    input  logic [2:0]            BranchType,
    input  logic                  call,
    input  logic                  ret,
    input  logic [11:0]           Address,
    input  logic [15:0]           retAddr,
    input  logic [15:0]           pc_addr,
    input  logic                  V,
    input  logic                  Z,
    input  logic                  N,
    input  logic                  run,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [15:0]           ALU_result,
    input  logic [15:0]           data_r2,
    mem_stage_ctrl_if.master      mem,
    output logic [15:0]           rdata_q,
    output logic                  stall,
    output logic                  pc_redirect,
    output logic [15:0]           pc_target,
    output logic                  flush,
    output logic                  halted,
    output logic                  ras_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [RAS_PTR_W:0]   CNT_FULL = (RAS_PTR_W + 1)'(RAS_DEPTH);
    localparam logic [RAS_PTR_W:0]   CNT_ONE  = (RAS_PTR_W + 1)'(1);
    localparam logic [RAS_PTR_W-1:0] PTR_ONE  = RAS_PTR_W'(1);

    state_t               state;
    logic [RAS_PTR_W-1:0] ras_ptr;   // next free slot
    logic [RAS_PTR_W:0]   ras_cnt;   // valid entries, saturates at RAS_DEPTH
    logic [15:0]          ras_mem [RAS_DEPTH];

    logic                 active, access, is_read, req, retire;
    logic                 ras_empty, ras_full, taken;
    logic [RAS_PTR_W-1:0] top_idx;
    logic [15:0]          br_target;
    logic                 redirect, do_pop, do_push, ret_err;
    logic [15:0]          target;

    // Only the page bits of the PC form the target; the rest is intentionally unused.
    logic unused_pc_low;
    assign unused_pc_low = ^pc_addr[11:0];

    // Gating with rst_n makes mem_req drop the instant reset asserts, even mid-WAIT.
    assign active  = rst_n && !halted;
    assign access  = MemRead | MemWrite;
    assign is_read = MemRead & ~MemWrite;   // both set counts as a write
    // In WAIT the request fields come straight from the held EX/MEM inputs.
    assign req     = active && (state == S_WAIT || access);
    assign stall   = req && !mem.mem_ack;
    assign retire  = active && !stall;

    assign mem.mem_req   = req;
    assign mem.mem_we    = req & MemWrite;
    assign mem.mem_addr  = req ? ALU_result : 16'h0000;
    assign mem.mem_wdata = req ? data_r2    : 16'h0000;

    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_FULL);
    assign top_idx   = ras_ptr - PTR_ONE;
    assign br_target = {pc_addr[15:12], Address};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        taken = 1'b0;
        case (BranchType)
            3'd0: taken = Z;
            3'd1: taken = !Z;
            3'd2: taken = N ^ V;
            3'd3: taken = !(N ^ V);
            3'd4: taken = !Z && !(N ^ V);
            3'd5: taken = Z || (N ^ V);
            3'd6: taken = V;
            default: taken = 1'b1;
        endcase
    end

    // Redirect resolution; only a retiring instruction may act.
    always_comb begin
        redirect = 1'b0;
        target   = 16'h0000;
        do_pop   = 1'b0;
        do_push  = 1'b0;
        ret_err  = 1'b0;
        if (retire) begin
            if (ret) begin
                redirect = 1'b1;
                if (ras_empty) begin
                    // Underflow: target stays 0 and the stack is left alone, even with call.
                    ret_err = 1'b1;
                end else begin
                    target  = ras_mem[top_idx];
                    do_pop  = 1'b1;
                    do_push = call;
                end
            end else if (call) begin
                redirect = 1'b1;
                target   = br_target;
                do_push  = 1'b1;
            end else if (Branch && taken) begin
                redirect = 1'b1;
                target   = br_target;
            end
        end
    end

    assign pc_redirect = redirect;
    assign flush       = redirect;
    assign pc_target   = target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ras_ptr <= '0;
            ras_cnt <= '0;
            rdata_q <= '0;
            halted  <= 1'b0;
            ras_err <= 1'b0;
            // NOTE: the stack storage is reset explicitly so a read of a stale slot is deterministic.
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            // NOTE: state is updated with <= so every register samples pre-edge values.
            state <= stall ? S_WAIT : S_IDLE;

            if (req && mem.mem_ack && is_read) begin
                rdata_q <= mem.mem_rdata;
            end

            if (retire && !run) begin
                halted <= 1'b1;
            end

            if (ret_err) begin
                ras_err <= 1'b1;
            end

            if (do_pop && do_push) begin
                // Pop then push: the freed top slot takes the new return address.
                ras_mem[top_idx] <= retAddr;
            end else if (do_pop) begin
                ras_ptr <= top_idx;
                ras_cnt <= ras_cnt - CNT_ONE;
            end else if (do_push) begin
                // On a full stack the pointer wraps and overwrites the oldest entry.
                ras_mem[ras_ptr] <= retAddr;
                ras_ptr          <= ras_ptr + PTR_ONE;
                if (ras_full) begin
                    ras_err <= 1'b1;
                end else begin
                    ras_cnt <= ras_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller fed directly by the EX/MEM pipeline register outputs.
- Resolves conditional branches, jumps, calls and returns using a hardware return-address stack (RAS), and produces the PC redirect and pipeline flush.
- Runs a data-memory request/acknowledge handshake, stalling the pipeline while memory is busy.
- Latches the halt (run=0) condition; read data and results flow on to the MEM/WB register.

Parameters:
- RAS_DEPTH, 8, number of return-address stack entries (power of 2, >=2).
- RAS_PTR_W, 3, log2(RAS_DEPTH).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Branch  in  1  instruction is a branch/jump
- BranchType  in  3  condition select
- call  in  1  instruction is a call
- ret  in  1  instruction is a return
- Address  in  12  branch/jump target low bits
- retAddr  in  16  return address to push on call
- pc_addr  in  16  PC of the instruction in MEM
- V, Z, N  in  1 each  ALU flags
- run  in  1  0 = halt instruction
- MemRead, MemWrite  in  1 each  memory access request
- ALU_result  in  16  memory address / result
- data_r2  in  16  store data
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  16  memory address
- mem_wdata  out  16  store data
- mem_ack  in  1  memory done (read data valid this cycle)
- mem_rdata  in  16  read data
- rdata_q  out  16  captured read data to MEM/WB
- stall  out  1  hold PC/IF/ID/ID-EX/EX-MEM; bubble MEM/WB
- pc_redirect  out  1  load pc_target
- pc_target  out  16  redirect address
- flush  out  1  clear IF/ID, ID/EX, EX/MEM
- halted  out  1  sticky halt
- ras_err  out  1  sticky RAS underflow/overflow

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE, RAS pointer=0, count=0, all entries 0, rdata_q=0, halted=0, ras_err=0. All outputs 0.
- When halted=1, all inputs are ignored: mem_req=0, pc_redirect=0, stall=0. halted only clears on reset.
- "Retire" = the cycle the instruction leaves MEM. Retire = (stall==0) && !halted.
  - RAS updates, halted and ras_err change only on retire.
  - A stalled instruction therefore acts exactly once.
- Memory FSM:
  - IDLE, access = MemRead|MemWrite:
    - mem_req=1, mem_we=MemWrite; mem_addr=ALU_result, mem_wdata=data_r2 (combinational).
    - If mem_ack is high in the same cycle: stall=0, rdata_q<=mem_rdata on a read, stay in IDLE.
    - Otherwise: stall=1, go to WAIT.
  - WAIT:
    - mem_req=1, request fields held (inputs are stable because the upstream stages are stalled), stall=1.
    - On mem_ack: rdata_q<=mem_rdata on a read, stall=0 that cycle, go to IDLE.
  - MemRead and MemWrite both set: treated as a write.
- Branch condition by BranchType: 0 Z; 1 !Z; 2 N^V; 3 !(N^V); 4 !Z&!(N^V); 5 Z|(N^V); 6 V; 7 always.
- Target: {pc_addr[15:12], Address}.
- Redirect priority (evaluated only on retire): ret > call > taken Branch.
  - ret, RAS non-empty: pc_target = top entry; pop.
  - ret, RAS empty: pc_target = 16'h0000; ras_err<=1; pointer unchanged.
  - call: pc_target = branch target; push retAddr.
    - Full RAS: write wraps over the oldest entry, count stays RAS_DEPTH, ras_err<=1.
  - ret and call together: pop, then push retAddr into the freed slot (net count unchanged); pc_target = popped value.
  - Taken Branch: pc_target = branch target.
- Any redirect drives pc_redirect=1 and flush=1 combinationally in the retire cycle. No redirect while stall=1.
- run=0 on retire: halted<=1 next edge. A redirect in the same retire cycle is still issued.
- Reset mid-WAIT: FSM returns to IDLE and mem_req drops immediately.

Test Plan:
- BranchType=0, Z=1, Branch=1, pc_addr=16'h3456, Address=12'hABC -> pc_redirect=1, flush=1, pc_target=16'h3ABC; repeat with Z=0 -> no redirect.
- call with retAddr=16'h0101, then ret -> call target per Address; ret gives pc_target=16'h0101, RAS empty afterwards.
- ret on empty RAS -> pc_target=16'h0000, ras_err=1 from next cycle.
- 9 calls with RAS_DEPTH=8 -> ras_err=1; following 8 rets return retAddrs 9..2 in LIFO order.
- MemRead at ALU_result=16'h0040, mem_ack after 3 cycles, mem_rdata=16'hBEEF -> stall high for 3 cycles, rdata_q=16'hBEEF.
- MemRead with zero-wait ack -> no stall cycle.
- run=0 retire -> halted=1; later MemWrite produces no mem_req. Assert rst_n=0 mid-WAIT -> mem_req=0 asynchronously, halted=0.
